// File: rtl/sobel_pkg.sv
`default_nettype none
// sobel_pkg: shared sequencer state encoding, counter width helper and line-buffer rotation.
// Revision: 1.0
package sobel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    // Counter width for n distinct values; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] next_buf(input logic [1:0] sel);
        return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_pos_cnt.sv
`default_nettype none
// sobel_pos_cnt: saturating column counter and row counter, stepped by real or synthetic pixels.
// Revision: 1.0
module sobel_pos_cnt
    import sobel_pkg::*;
#(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480,
    parameter int CNT_W   = width_of(IMAGE_W + 1),
    parameter int ROW_W   = width_of(IMAGE_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_step,
    input  logic             i_line_end,
    output logic [CNT_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_col_full,
    output logic             o_last_row
);

    logic [CNT_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_col_full = (r_col == CNT_W'(IMAGE_W));
    assign o_last_row = (r_row == ROW_W'(IMAGE_H - 1));

    // The column count saturates at W so an overlong line still ends with a full count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            if (i_line_end) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else if (i_step && !o_col_full) begin
                r_col <= r_col + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_line_sched.sv
`default_nettype none
// sobel_line_sched: line/frame sequencer driving three rotating line buffers and the 3x3 window strobes.
// Optional vertical-blanking flush line enabled by SOBEL_SCHED_FLUSH_EN. Revision: 1.0
module sobel_line_sched
    import sobel_pkg::*;
#(
    parameter int IMAGE_W   = 640,
    parameter int IMAGE_H   = 480,
    parameter int FLUSH_GAP = 4,
    parameter int COL_W     = width_of(IMAGE_W),
    parameter int ROW_W     = width_of(IMAGE_H)
) (
    input  logic             InVideoClk,
    input  logic             InRst,
    input  logic             InVideoVs,
    input  logic             InVideoDe,
    output logic             OutLbWrEn,
    output logic [1:0]       OutLbWrSel,
    output logic [COL_W-1:0] OutLbAddr,
    output logic             OutWinValid,
    output logic [ROW_W-1:0] OutRow,
    output logic [COL_W-1:0] OutCol,
    output logic             OutBorder,
    output logic             OutVideoVs,
    output logic             OutFrameErr
);

    localparam int CNT_W = width_of(IMAGE_W + 1);
    localparam int GAP_W = width_of(FLUSH_GAP + 1);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMAGE_W - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMAGE_H - 1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(FLUSH_GAP - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_vs_d;
    logic             r_de_d;
    logic [GAP_W-1:0] r_gap;
    logic             r_flush_go;
    logic [CNT_W-1:0] w_col;
    logic [ROW_W-1:0] w_row_in;
    logic             w_col_full;
    logic             w_last_row;
    logic             w_vs_rise;
    logic             w_de_fall;
    logic             w_active;
    logic             w_pix;
    logic             w_line_end;
    logic             w_syn;
    logic             w_step;
    logic [COL_W-1:0] w_col_lo;
    logic [COL_W-1:0] w_col_m1;
    logic [ROW_W-1:0] w_row_m1;
    logic             w_border_run;

    assign w_vs_rise  = InVideoVs & ~r_vs_d;
    assign w_de_fall  = r_de_d & ~InVideoDe;
    assign w_active   = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign w_pix      = w_active & InVideoDe & ~w_vs_rise;
    assign w_line_end = w_active & w_de_fall & ~w_vs_rise;
    assign w_syn      = (r_state == ST_FLUSH) & r_flush_go & ~w_vs_rise;
    assign w_step     = w_pix | (w_syn & ~w_col_full);
    assign OutVideoVs = r_vs_d;

    // Centre lags the sampled column by one and the written row by one.
    assign w_col_lo     = w_col[COL_W-1:0];
    assign w_col_m1     = w_col_lo - COL_W'(1);
    assign w_row_m1     = w_row_in - ROW_W'(1);
    assign w_border_run = (w_row_m1 == '0) || (w_row_m1 == c_row_last) ||
                          (w_col_m1 == '0) || (w_col_m1 == c_col_last);

    sobel_pos_cnt #(
        .IMAGE_W (IMAGE_W),
        .IMAGE_H (IMAGE_H),
        .CNT_W   (CNT_W),
        .ROW_W   (ROW_W)
    ) u_pos_cnt (
        .clk        (InVideoClk),
        .rst        (InRst),
        .i_clr      (w_vs_rise),
        .i_step     (w_step),
        .i_line_end (w_line_end),
        .o_col      (w_col),
        .o_row      (w_row_in),
        .o_col_full (w_col_full),
        .o_last_row (w_last_row)
    );

    always_ff @(posedge InVideoClk or posedge InRst) begin
        if (InRst) begin
            r_state <= ST_IDLE;
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_vs_d  <= InVideoVs;
            r_de_d  <= InVideoDe;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_vs_rise) begin
            w_next_state = ST_FILL;
        end else begin
            case (r_state)
                ST_FILL:  if (w_line_end) w_next_state = ST_RUN;
                ST_RUN: begin
                    if (w_line_end && w_last_row) begin
`ifdef SOBEL_SCHED_FLUSH_EN
                        w_next_state = ST_FLUSH;
`else
                        w_next_state = ST_WAIT;
`endif
                    end
                end
                ST_FLUSH: if (w_syn && w_col_full) w_next_state = ST_WAIT;
                default:  w_next_state = r_state;
            endcase
        end
    end

    // Synthetic flush pixels start only after FLUSH_GAP consecutive DE-low samples.
    always_ff @(posedge InVideoClk or posedge InRst) begin
        if (InRst) begin
            r_gap      <= '0;
            r_flush_go <= 1'b0;
        end else if (w_vs_rise || (r_state != ST_FLUSH)) begin
            r_gap      <= '0;
            r_flush_go <= 1'b0;
        end else if (!r_flush_go) begin
            if (InVideoDe) begin
                r_gap <= '0;
            end else if (r_gap == c_gap_last) begin
                r_flush_go <= 1'b1;
            end else begin
                r_gap <= r_gap + GAP_W'(1);
            end
        end
    end

    always_ff @(posedge InVideoClk or posedge InRst) begin
        if (InRst) begin
            OutLbWrEn   <= 1'b0;
            OutLbWrSel  <= 2'd0;
            OutLbAddr   <= '0;
            OutWinValid <= 1'b0;
            OutRow      <= '0;
            OutCol      <= '0;
            OutBorder   <= 1'b0;
            OutFrameErr <= 1'b0;
        end else begin
            OutLbWrEn   <= 1'b0;
            OutWinValid <= 1'b0;
            OutBorder   <= 1'b0;
            if (w_vs_rise) begin
                OutLbWrSel  <= 2'd0;
                OutLbAddr   <= '0;
                OutRow      <= '0;
                OutCol      <= '0;
                OutFrameErr <= (r_state == ST_FILL) || (r_state == ST_RUN) ||
                               (r_state == ST_FLUSH);
            end else begin
                if (w_pix) begin
                    if (w_col_full) begin
                        OutFrameErr <= 1'b1;
                    end else begin
                        OutLbWrEn <= 1'b1;
                        OutLbAddr <= w_col_lo;
                        if ((r_state == ST_RUN) && (w_col != '0)) begin
                            OutWinValid <= 1'b1;
                            OutRow      <= w_row_m1;
                            OutCol      <= w_col_m1;
                            OutBorder   <= w_border_run;
                        end
                    end
                end
                if (w_line_end) begin
                    OutLbWrSel <= next_buf(OutLbWrSel);
                    if (!w_col_full) begin
                        OutFrameErr <= 1'b1;
                    end else if (r_state == ST_RUN) begin
                        OutLbAddr   <= c_col_last;
                        OutWinValid <= 1'b1;
                        OutRow      <= w_row_m1;
                        OutCol      <= c_col_last;
                        OutBorder   <= 1'b1;
                    end
                end
                if ((r_state == ST_FLUSH) && InVideoDe) begin
                    OutFrameErr <= 1'b1;
                end
                if (w_syn) begin
                    OutRow <= c_row_last;
                    if (!w_col_full) begin
                        OutLbAddr <= w_col_lo;
                        if (w_col != '0) begin
                            OutWinValid <= 1'b1;
                            OutCol      <= w_col_m1;
                            OutBorder   <= 1'b1;
                        end
                    end else begin
                        OutLbAddr   <= c_col_last;
                        OutWinValid <= 1'b1;
                        OutCol      <= c_col_last;
                        OutBorder   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_line_sched.sv
`default_nettype none
// tb_sobel_line_sched: scoreboard bench for sobel_line_sched on an 8x4 image.
// Revision: 1.0
module tb_sobel_line_sched;

    localparam int W = 8;
    localparam int H = 4;
`ifdef SOBEL_SCHED_FLUSH_EN
    localparam int EXP_FRAME   = 32;
    localparam int EXP_BORDER  = 20;
    localparam int EXP_MAX_ROW = 3;
`else
    localparam int EXP_FRAME   = 24;
    localparam int EXP_BORDER  = 12;
    localparam int EXP_MAX_ROW = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vs  = 1'b0;
    logic       de  = 1'b0;
    logic       o_wr_en;
    logic [1:0] o_wr_sel;
    logic [2:0] o_addr;
    logic       o_valid;
    logic [1:0] o_row;
    logic [2:0] o_col;
    logic       o_border;
    logic       o_vs;
    logic       o_err;

    int tests    = 0;
    int fails    = 0;
    int n_valid  = 0;
    int n_border = 0;
    int max_row  = 0;
    int win_q[$];
    int wr_q[$];

    sobel_line_sched #(
        .IMAGE_W   (W),
        .IMAGE_H   (H),
        .FLUSH_GAP (4)
    ) dut (
        .InVideoClk  (clk),
        .InRst       (rst),
        .InVideoVs   (vs),
        .InVideoDe   (de),
        .OutLbWrEn   (o_wr_en),
        .OutLbWrSel  (o_wr_sel),
        .OutLbAddr   (o_addr),
        .OutWinValid (o_valid),
        .OutRow      (o_row),
        .OutCol      (o_col),
        .OutBorder   (o_border),
        .OutVideoVs  (o_vs),
        .OutFrameErr (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every window strobe and every buffer write must match the next expectation.
    initial forever begin
        @(negedge clk);
        if (o_valid) begin
            n_valid++;
            if (o_border) n_border++;
            if (int'(o_row) > max_row) max_row = int'(o_row);
            if (win_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL window_unexpected: actual row=%0d col=%0d required no window", o_row, o_col);
            end else begin
                int e;
                e = win_q.pop_front();
                check("window(row*100+col*10+border)",
                      int'(o_row) * 100 + int'(o_col) * 10 + int'(o_border), e);
            end
        end else if (o_border) begin
            tests++;
            fails++;
            $display("FAIL border_idle: actual=1 required=0");
        end
        if (o_wr_en) begin
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL write_unexpected: actual sel=%0d addr=%0d required no write", o_wr_sel, o_addr);
            end else begin
                int e;
                e = wr_q.pop_front();
                check("write(sel*100+addr)", int'(o_wr_sel) * 100 + int'(o_addr), e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_edge();
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
        tick();
    endtask

    task automatic push_win(input int r, input int c);
        int b;
        b = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 1 : 0;
        win_q.push_back(r * 100 + c * 10 + b);
    endtask

    // n pixels into buffer sel; crow < 0 means the fill line emits no windows.
    task automatic line(input int n, input int sel, input int crow, input int idle);
        for (int k = 0; k < n && k < W; k++) wr_q.push_back(sel * 100 + k);
        if (crow >= 0) begin
            for (int c = 0; c < W; c++) begin
                if (n >= W || c <= n - 2) push_win(crow, c);
            end
        end
        de = 1'b1;
        repeat (n) tick();
        de = 1'b0;
        repeat (idle) tick();
    endtask

    task automatic frame(input int long_row, input int last_idle);
        for (int r = 0; r < H; r++) begin
            line((r == long_row) ? W + 1 : W, r % 3, r - 1, (r == H - 1) ? last_idle : 3);
        end
`ifdef SOBEL_SCHED_FLUSH_EN
        for (int c = 0; c < W; c++) push_win(H - 1, c);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"},  int'(o_wr_en),  0);
        check({tag, "_wr_sel"}, int'(o_wr_sel), 0);
        check({tag, "_addr"},   int'(o_addr),   0);
        check({tag, "_valid"},  int'(o_valid),  0);
        check({tag, "_row"},    int'(o_row),    0);
        check({tag, "_col"},    int'(o_col),    0);
        check({tag, "_border"}, int'(o_border), 0);
        check({tag, "_vs"},     int'(o_vs),     0);
        check({tag, "_err"},    int'(o_err),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int b0;
        int lat;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Clean frame
        vs = 1'b1;
        tick();
        check("vs_delay", int'(o_vs), 1);
        tick();
        vs = 1'b0;
        tick();
        v0 = n_valid;
        b0 = n_border;
        frame(-1, 3);
        repeat (25) tick();
        check("frame_valid_count", n_valid - v0, EXP_FRAME);
        check("frame_border_count", n_border - b0, EXP_BORDER);
        check("frame_max_row", max_row, EXP_MAX_ROW);
        check("frame_err_clean", int'(o_err), 0);
        check("frame_queues_empty", win_q.size() + wr_q.size(), 0);

        // Overlong input row 2
        vs_edge();
        v0 = n_valid;
        frame(2, 3);
        check("long_err_set", int'(o_err), 1);
        repeat (25) tick();
        check("long_valid_count", n_valid - v0, EXP_FRAME);
        check("long_err_sticky", int'(o_err), 1);
        vs_edge();
        check("long_err_cleared", int'(o_err), 0);

        // Abort after two lines, then a full frame
        line(W, 0, -1, 3);
        line(W, 1, 0, 3);
        vs_edge();
        check("abort_err", int'(o_err), 1);
        v0 = n_valid;
        frame(-1, 3);
        repeat (25) tick();
        check("abort_next_valid_count", n_valid - v0, EXP_FRAME);
        check("abort_err_sticky", int'(o_err), 1);
        check("abort_queues_empty", win_q.size() + wr_q.size(), 0);

        // DE pulse two cycles after the last line
        vs_edge();
        check("gap_err_cleared", int'(o_err), 0);
        frame(-1, 2);
        de = 1'b1;
        tick();
        de = 1'b0;
`ifdef SOBEL_SCHED_FLUSH_EN
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (o_valid && lat < 0) lat = i;
        end
        check("flush_first_window_after_gap(>=5)", (lat >= 5) ? 1 : 0, 1);
        check("flush_de_err", int'(o_err), 1);
`else
        lat = 0;
        repeat (30) tick();
        check("wait_de_ignored_err", int'(o_err), lat);
`endif
        check("gap_queues_empty", win_q.size() + wr_q.size(), 0);

        // Reset in the middle of input row 2
        vs_edge();
        line(W, 0, -1, 3);
        line(W, 1, 0, 3);
        for (int k = 0; k < 4; k++) wr_q.push_back(200 + k);
        for (int c = 0; c < 3; c++) push_win(1, c);
        de = 1'b1;
        repeat (4) tick();
        #6;
        rst = 1'b1;
        de  = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        v0 = n_valid;
        de = 1'b1;
        repeat (W) tick();
        de = 1'b0;
        repeat (3) tick();
        check("idle_line_no_windows", n_valid - v0, 0);
        vs_edge();
        v0 = n_valid;
        frame(-1, 3);
        repeat (25) tick();
        check("post_reset_valid_count", n_valid - v0, EXP_FRAME);
        check("post_reset_err", int'(o_err), 0);
        check("final_queues_empty", win_q.size() + wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
